// File: rtl/intra_pkg.sv
// Shared constants, sample type and helpers for the intra X/Y exchange and write-address stages.
package intra_pkg;

  localparam int BIT_DEPTH_DEF = 8;
  localparam int BLK_DEF       = 8;

  typedef logic [BIT_DEPTH_DEF-1:0] sample_t;

  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic logic xpose_flag(input logic mode_hor, input logic is_inter);
    return mode_hor && !is_inter;
  endfunction

endpackage

// File: rtl/intra_xpose_bank.sv
// One BLKxBLK sample bank: row write port, block tag registers, combinational direct/transposed row read.
module intra_xpose_bank
  import intra_pkg::*;
#(
  parameter int BIT_DEPTH = BIT_DEPTH_DEF,
  parameter int BLK       = BLK_DEF,
  parameter int CW        = 3,
  localparam int IW       = log2c(BLK),
  localparam int ROW_W    = BLK * BIT_DEPTH
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    wr_idx,
  input  logic [ROW_W-1:0] wr_row,
  input  logic             tag_we,
  input  logic             mode_hor,
  input  logic             is_inter,
  input  logic [CW-1:0]    tag_x_in,
  input  logic [CW-1:0]    tag_y_in,
  input  logic [IW-1:0]    rd_idx,
  output logic [ROW_W-1:0] rd_row,
  output logic             xpose,
  output logic [CW-1:0]    tag_x,
  output logic [CW-1:0]    tag_y
);

  logic [ROW_W-1:0] mem [BLK];

  // Storage and tags carry no reset; validity lives in the top-level full flags.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_row;
    if (tag_we) begin
      xpose <= xpose_flag(mode_hor, is_inter);
      tag_x <= tag_x_in;
      tag_y <= tag_y_in;
    end
  end

  always_comb begin
    rd_row = '0;
    for (int c = 0; c < BLK; c++)
      rd_row[c*BIT_DEPTH +: BIT_DEPTH] = xpose ? mem[c][rd_idx*BIT_DEPTH +: BIT_DEPTH]
                                               : mem[rd_idx][c*BIT_DEPTH +: BIT_DEPTH];
  end

endmodule

// File: rtl/intra_xpose_pingpong.sv
// Two-bank ping-pong row buffer that transposes intra horizontal-class blocks on readout.
// Optional block/transpose performance counters are enabled by defining INTRA_XPOSE_CNT_EN.
module intra_xpose_pingpong
  import intra_pkg::*;
#(
  parameter int BIT_DEPTH = BIT_DEPTH_DEF,
  parameter int BLK       = BLK_DEF,
  parameter int CW        = 3,
  localparam int IW       = log2c(BLK),
  localparam int ROW_W    = BLK * BIT_DEPTH
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_mode_hor,
  input  logic             in_is_inter,
  input  logic [CW-1:0]    in_x,
  input  logic [CW-1:0]    in_y,
  input  logic [ROW_W-1:0] in_row,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic [IW-1:0]    out_idx,
  output logic             out_last,
  output logic [CW-1:0]    out_x,
  output logic [CW-1:0]    out_y,
  output logic             err_resync
`ifdef INTRA_XPOSE_CNT_EN
  ,
  output logic [15:0]      perf_blk_cnt,
  output logic [15:0]      perf_xpose_cnt
`endif
);

  logic [1:0]       full;
  logic             wr_bank, rd_bank;
  logic [IW-1:0]    wr_cnt, rd_cnt;
  logic             accept, resync, wr_done, rd_hs, rd_done;
  logic [IW-1:0]    wr_idx;
  logic [ROW_W-1:0] bank_row [2];
  logic [CW-1:0]    bank_x [2];
  logic [CW-1:0]    bank_y [2];
  logic [1:0]       bank_xp;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign accept    = in_valid && in_ready;
  // A first row always lands in row 0, discarding whatever partial block preceded it.
  assign wr_idx    = in_first ? '0 : wr_cnt;
  assign resync    = accept && in_first && (wr_cnt != '0);
  assign wr_done   = accept && (wr_idx == IW'(BLK - 1));
  assign rd_hs     = out_valid && out_ready;
  assign rd_done   = rd_hs && (rd_cnt == IW'(BLK - 1));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    intra_xpose_bank #(.BIT_DEPTH(BIT_DEPTH), .BLK(BLK), .CW(CW)) u_bank (
      .clk      (clk),
      .we       (accept && (wr_bank == 1'(b))),
      .wr_idx   (wr_idx),
      .wr_row   (in_row),
      .tag_we   (accept && in_first && (wr_bank == 1'(b))),
      .mode_hor (in_mode_hor),
      .is_inter (in_is_inter),
      .tag_x_in (in_x),
      .tag_y_in (in_y),
      .rd_idx   (rd_cnt),
      .rd_row   (bank_row[b]),
      .xpose    (bank_xp[b]),
      .tag_x    (bank_x[b]),
      .tag_y    (bank_y[b])
    );
  end

  // Outputs are forced to zero while idle so uninitialised storage never shows.
  assign out_row  = out_valid ? bank_row[rd_bank] : '0;
  assign out_idx  = rd_cnt;
  assign out_last = (rd_cnt == IW'(BLK - 1));
  assign out_x    = !out_valid ? '0 : (bank_xp[rd_bank] ? bank_y[rd_bank] : bank_x[rd_bank]);
  assign out_y    = !out_valid ? '0 : (bank_xp[rd_bank] ? bank_x[rd_bank] : bank_y[rd_bank]);

  // A completing write and a completing read always target different banks.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      full       <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      err_resync <= 1'b0;
    end else begin
      err_resync <= resync;
      if (accept) begin
        wr_cnt <= wr_done ? '0 : wr_idx + 1'b1;
        if (wr_done) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (rd_hs) begin
        rd_cnt <= rd_done ? '0 : rd_cnt + 1'b1;
        if (rd_done) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end

`ifdef INTRA_XPOSE_CNT_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      perf_blk_cnt   <= '0;
      perf_xpose_cnt <= '0;
    end else if (rd_done) begin
      if (perf_blk_cnt != 16'hFFFF) perf_blk_cnt <= perf_blk_cnt + 16'd1;
      if (bank_xp[rd_bank] && perf_xpose_cnt != 16'hFFFF) perf_xpose_cnt <= perf_xpose_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_intra_xpose_pingpong.sv
// Directed bench: 8x8/8-bit main instance plus a 4x4/10-bit instance for the parameter sweep.
module tb_intra_xpose_pingpong;
  import intra_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  // main instance, BLK=8, BIT_DEPTH=8
  logic        in_valid = 0, in_first = 0, in_mode_hor = 0, in_is_inter = 0;
  logic [2:0]  in_x = 0, in_y = 0;
  logic [63:0] in_row = 0;
  logic        in_ready, out_valid, out_last, err_resync;
  logic        out_ready = 0;
  logic [63:0] out_row;
  logic [2:0]  out_idx, out_x, out_y;

  // small instance, BLK=4, BIT_DEPTH=10
  logic        s_in_valid = 0, s_in_first = 0, s_in_mode_hor = 0;
  logic [2:0]  s_in_x = 0, s_in_y = 0;
  logic [39:0] s_in_row = 0;
  logic        s_in_ready, s_out_valid, s_out_last, s_err_resync;
  logic        s_out_ready = 0;
  logic [39:0] s_out_row;
  logic [1:0]  s_out_idx;
  logic [2:0]  s_out_x, s_out_y;

`ifdef INTRA_XPOSE_CNT_EN
  logic [15:0] perf_blk_cnt, perf_xpose_cnt, s_perf_blk_cnt, s_perf_xpose_cnt;
`endif

  intra_xpose_pingpong #(.BIT_DEPTH(8), .BLK(8), .CW(3)) dut (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_mode_hor(in_mode_hor), .in_is_inter(in_is_inter), .in_x(in_x), .in_y(in_y), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_idx(out_idx),
    .out_last(out_last), .out_x(out_x), .out_y(out_y), .err_resync(err_resync)
`ifdef INTRA_XPOSE_CNT_EN
    , .perf_blk_cnt(perf_blk_cnt), .perf_xpose_cnt(perf_xpose_cnt)
`endif
  );

  intra_xpose_pingpong #(.BIT_DEPTH(10), .BLK(4), .CW(3)) dut_s (
    .clk(clk), .arst_n(arst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_first(s_in_first),
    .in_mode_hor(s_in_mode_hor), .in_is_inter(1'b0), .in_x(s_in_x), .in_y(s_in_y), .in_row(s_in_row),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_row(s_out_row), .out_idx(s_out_idx),
    .out_last(s_out_last), .out_x(s_out_x), .out_y(s_out_y), .err_resync(s_err_resync)
`ifdef INTRA_XPOSE_CNT_EN
    , .perf_blk_cnt(s_perf_blk_cnt), .perf_xpose_cnt(s_perf_xpose_cnt)
`endif
  );

  function automatic logic [63:0] mk_row(input int base, input int r, input bit xp);
    logic [63:0] row;
    sample_t     s;
    row = '0;
    for (int c = 0; c < 8; c++) begin
      s = sample_t'(xp ? base + c*8 + r : base + r*8 + c);
      row[c*8 +: 8] = s;
    end
    return row;
  endfunction

  function automatic logic [39:0] mk_srow(input int r, input bit xp);
    logic [39:0] row;
    row = '0;
    for (int c = 0; c < 4; c++)
      row[c*10 +: 10] = 10'(xp ? 1000 + c*4 + r : 1000 + r*4 + c);
    return row;
  endfunction

  task automatic push_row(input logic [63:0] row, input bit first, input bit hor, input bit inter,
                          input logic [2:0] x, input logic [2:0] y);
    int n;
    in_valid = 1; in_row = row; in_first = first;
    in_mode_hor = first ? hor : ~hor;
    in_is_inter = first ? inter : ~inter;
    in_x = first ? x : ~x;
    in_y = first ? y : ~y;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0; in_first = 0;
  endtask

  task automatic send_block(input int base, input bit hor, input bit inter,
                            input logic [2:0] x, input logic [2:0] y);
    for (int r = 0; r < 8; r++) push_row(mk_row(base, r, 0), r == 0, hor, inter, x, y);
  endtask

  task automatic expect_block(input int base, input bit xp, input logic [2:0] ex,
                              input logic [2:0] ey, input int nrows, input string name);
    int n;
    out_ready = 1;
    for (int r = 0; r < nrows; r++) begin
      n = 0;
      while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
      total++;
      if (out_valid !== 1'b1) begin
        bad++; $display("FAIL %s_valid row %0d: got %0b want 1", name, r, out_valid);
      end
      total++;
      if (out_row !== mk_row(base, r, xp)) begin
        bad++; $display("FAIL %s_row %0d: got %h want %h", name, r, out_row, mk_row(base, r, xp));
      end
      total++;
      if (out_idx !== 3'(r) || out_last !== (r == 7)) begin
        bad++; $display("FAIL %s_idx row %0d: got idx=%0d last=%0b want idx=%0d last=%0b",
                        name, r, out_idx, out_last, r, r == 7);
      end
      total++;
      if (out_x !== ex || out_y !== ey) begin
        bad++; $display("FAIL %s_tag row %0d: got x=%0d y=%0d want x=%0d y=%0d",
                        name, r, out_x, out_y, ex, ey);
      end
      @(posedge clk); #1;
    end
    out_ready = 0;
  endtask

  task automatic test_reset;
    total++;
    if (in_ready !== 1 || out_valid !== 0 || out_row !== '0 || out_idx !== 0 || out_last !== 0 ||
        out_x !== 0 || out_y !== 0 || err_resync !== 0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%0b vld=%0b row=%h idx=%0d last=%0b x=%0d y=%0d err=%0b want 1 0 0 0 0 0 0 0",
               in_ready, out_valid, out_row, out_idx, out_last, out_x, out_y, err_resync);
    end
  endtask

  task automatic test_direct;
    out_ready = 0;
    for (int r = 0; r < 7; r++) push_row(mk_row(0, r, 0), r == 0, 0, 0, 3'd2, 3'd5);
    total++;
    if (out_valid !== 0) begin bad++; $display("FAIL direct_early_valid: got %0b want 0", out_valid); end
    push_row(mk_row(0, 7, 0), 0, 0, 0, 3'd2, 3'd5);
    total++;
    if (out_valid !== 1) begin bad++; $display("FAIL direct_latency: got %0b want 1", out_valid); end
    expect_block(0, 0, 3'd2, 3'd5, 8, "direct");
  endtask

  task automatic test_transpose;
    send_block(0, 1, 0, 3'd2, 3'd5);
    expect_block(0, 1, 3'd5, 3'd2, 8, "xpose");
  endtask

  task automatic test_inter;
    send_block(0, 1, 1, 3'd2, 3'd5);
    expect_block(0, 0, 3'd2, 3'd5, 8, "inter");
  endtask

  task automatic test_back_to_back;
    logic [63:0] held;
    out_ready = 0;
    send_block(0, 0, 0, 3'd1, 3'd4);
    send_block(64, 1, 0, 3'd2, 3'd6);
    total++;
    if (in_ready !== 0) begin bad++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
    held = out_row;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1 || out_row !== held || out_row !== mk_row(0, 0, 0)) begin
      bad++; $display("FAIL bp_hold: got vld=%0b row=%h want vld=1 row=%h", out_valid, out_row, mk_row(0, 0, 0));
    end
    fork
      send_block(128, 0, 1, 3'd3, 3'd7);
      begin
        expect_block(0, 0, 3'd1, 3'd4, 8, "bp_blk1");
        expect_block(64, 1, 3'd6, 3'd2, 8, "bp_blk2");
        expect_block(128, 0, 3'd3, 3'd7, 8, "bp_blk3");
      end
    join
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 0) begin bad++; $display("FAIL bp_extra_block: got vld=%0b want 0", out_valid); end
  endtask

  task automatic test_resync;
    out_ready = 0;
    push_row(mk_row(200, 0, 0), 1, 1, 0, 3'd7, 3'd7);
    push_row(mk_row(200, 1, 0), 0, 1, 0, 3'd7, 3'd7);
    total++;
    if (err_resync !== 0) begin bad++; $display("FAIL resync_idle: got %0b want 0", err_resync); end
    push_row(mk_row(16, 0, 0), 1, 0, 0, 3'd4, 3'd1);
    total++;
    if (err_resync !== 1) begin bad++; $display("FAIL resync_pulse: got %0b want 1", err_resync); end
    push_row(mk_row(16, 1, 0), 0, 0, 0, 3'd4, 3'd1);
    total++;
    if (err_resync !== 0) begin bad++; $display("FAIL resync_one_cycle: got %0b want 0", err_resync); end
    for (int r = 2; r < 8; r++) push_row(mk_row(16, r, 0), 0, 0, 0, 3'd4, 3'd1);
    expect_block(16, 0, 3'd4, 3'd1, 8, "resync");
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 0) begin bad++; $display("FAIL resync_extra: got vld=%0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    bit stale;
    out_ready = 0;
    send_block(32, 0, 0, 3'd1, 3'd1);
    send_block(96, 0, 0, 3'd2, 3'd2);
    expect_block(32, 0, 3'd1, 3'd1, 3, "mid");
    arst_n = 0;
    #1;
    total++;
    if (out_valid !== 0 || in_ready !== 1) begin
      bad++; $display("FAIL mid_reset_async: got vld=%0b rdy=%0b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 0 || in_ready !== 1 || out_idx !== 0) begin
      bad++; $display("FAIL mid_reset_edge: got vld=%0b rdy=%0b idx=%0d want 0 1 0", out_valid, in_ready, out_idx);
    end
    arst_n = 1;
    out_ready = 1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1;
    end
    out_ready = 0;
    total++;
    if (stale !== 0) begin bad++; $display("FAIL mid_stale: got %0b want 0", stale); end
    send_block(48, 1, 0, 3'd6, 3'd3);
    expect_block(48, 1, 3'd3, 3'd6, 8, "post_reset");
  endtask

  task automatic test_small(input bit hor);
    int n;
    s_out_ready = 0;
    for (int r = 0; r < 4; r++) begin
      s_in_valid = 1; s_in_first = (r == 0); s_in_mode_hor = (r == 0) ? hor : ~hor;
      s_in_x = (r == 0) ? 3'd1 : 3'd0; s_in_y = (r == 0) ? 3'd6 : 3'd0;
      s_in_row = mk_srow(r, 0);
      n = 0;
      while (!s_in_ready && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
    end
    s_in_valid = 0; s_in_first = 0;
    total++;
    if (s_out_valid !== 1) begin bad++; $display("FAIL small_latency: got %0b want 1", s_out_valid); end
    s_out_ready = 1;
    for (int r = 0; r < 4; r++) begin
      total++;
      if (s_out_row !== mk_srow(r, hor) || s_out_idx !== 2'(r) || s_out_last !== (r == 3)) begin
        bad++; $display("FAIL small_row hor=%0b r=%0d: got %h idx=%0d last=%0b want %h idx=%0d",
                        hor, r, s_out_row, s_out_idx, s_out_last, mk_srow(r, hor), r);
      end
      total++;
      if (s_out_x !== (hor ? 3'd6 : 3'd1) || s_out_y !== (hor ? 3'd1 : 3'd6)) begin
        bad++; $display("FAIL small_tag hor=%0b: got x=%0d y=%0d", hor, s_out_x, s_out_y);
      end
      @(posedge clk); #1;
    end
    s_out_ready = 0;
    total++;
    if (s_out_valid !== 0) begin bad++; $display("FAIL small_drain: got %0b want 0", s_out_valid); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    arst_n = 1;
    @(posedge clk); #1;
    test_direct;
    test_transpose;
    test_inter;
    test_back_to_back;
    test_resync;
    test_reset_mid;
    test_small(0);
    test_small(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
